dcache_flush_ctrl: RTL and testbench

DCACHE_FLUSH_CTRL -- requirements
Module: dcache_flush_ctrl

---
 rtl/wt_cache_pkg.sv | 24 ++
 rtl/flush_cnt_sat.sv | 34 +++
 rtl/dcache_flush_ctrl.sv | 113 +++++++++++
 tb/tb_dcache_flush_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared write-through dcache definitions: core cache geometry and the flush FSM state type.
package wt_cache_pkg;

  localparam int unsigned DCacheByteSize  = 32768;
  localparam int unsigned DCacheSetAssoc  = 8;
  localparam int unsigned DCacheLineWidth = 128;

  function automatic int unsigned dcache_num_sets(input int unsigned byte_size,
                                                  input int unsigned assoc,
                                                  input int unsigned line_width);
    return byte_size / (assoc * (line_width / 8));
  endfunction

  localparam int unsigned DCacheNumSets =
      dcache_num_sets(DCacheByteSize, DCacheSetAssoc, DCacheLineWidth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WALK  = 2'd2,
    DONE  = 2'd3
  } flush_state_e;

endpackage

// File: rtl/flush_cnt_sat.sv
// Saturating cycle counter used to measure flush duration.
module flush_cnt_sat #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  // Clear wins over count; the value sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_flush_ctrl.sv
// Dcache flush controller: waits for the write buffer to drain, then invalidates all ways of every set.
// Define DCACHE_FLUSH_CYCLE_CNT_EN to report the duration of the last flush on flush_cycles_o.
module dcache_flush_ctrl
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumSets = DCacheNumSets,
  parameter int unsigned NumWays = DCacheSetAssoc,
  parameter int unsigned SetIdxW = $clog2(NumSets)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_req_i,
  input  logic               wbuf_empty_i,
  input  logic               tag_gnt_i,
  output logic               busy_o,
  output logic               flush_ack_o,
  output logic               tag_req_o,
  output logic               tag_we_o,
  output logic [SetIdxW-1:0] tag_set_o,
  output logic [NumWays-1:0] tag_way_mask_o,
  output logic [31:0]        flush_cycles_o
);

  localparam logic [SetIdxW-1:0] LastSet = SetIdxW'(NumSets - 1);

  flush_state_e       state_q;
  logic [SetIdxW-1:0] set_q;
  logic               busy_q;
  logic               ack_q;
  logic               tag_req_q;
  logic               tag_we_q;
  logic [NumWays-1:0] way_mask_q;

  // The set counter doubles as tag_set_o, so it is zeroed whenever the walk ends.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      set_q      <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      tag_req_q  <= 1'b0;
      tag_we_q   <= 1'b0;
      way_mask_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_req_i) begin
            state_q <= DRAIN;
            set_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (wbuf_empty_i) begin
            state_q    <= WALK;
            tag_req_q  <= 1'b1;
            tag_we_q   <= 1'b1;
            way_mask_q <= '1;
          end
        end
        WALK: begin
          if (tag_gnt_i) begin
            if (set_q == LastSet) begin
              state_q    <= DONE;
              set_q      <= '0;
              tag_req_q  <= 1'b0;
              tag_we_q   <= 1'b0;
              way_mask_q <= '0;
              ack_q      <= 1'b1;
            end else begin
              set_q <= set_q + SetIdxW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign flush_ack_o    = ack_q;
  assign tag_req_o      = tag_req_q;
  assign tag_we_o       = tag_we_q;
  assign tag_set_o      = set_q;
  assign tag_way_mask_o = way_mask_q;

`ifdef DCACHE_FLUSH_CYCLE_CNT_EN
  // busy_q covers exactly the DRAIN, WALK and DONE cycles of a flush.
  logic flush_start;
  assign flush_start = (state_q == IDLE) && flush_req_i;

  flush_cnt_sat #(
    .Width(32)
  ) u_flush_cnt_sat (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (flush_start),
    .en_i  (busy_q),
    .cnt_o (flush_cycles_o)
  );
`else
  assign flush_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Directed bench for dcache_flush_ctrl: table of flush scenarios plus held-request and reset sequences.
module tb_dcache_flush_ctrl;

`ifdef DCACHE_FLUSH_CYCLE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_req_i = 1'b0;
  logic        wbuf_empty_i = 1'b0;
  logic        tag_gnt_i = 1'b0;
  logic        busy_o, flush_ack_o, tag_req_o, tag_we_o;
  logic [7:0]  tag_set_o, tag_way_mask_o;
  logic [31:0] flush_cycles_o;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_flush_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_req_i   (flush_req_i),
    .wbuf_empty_i  (wbuf_empty_i),
    .tag_gnt_i     (tag_gnt_i),
    .busy_o        (busy_o),
    .flush_ack_o   (flush_ack_o),
    .tag_req_o     (tag_req_o),
    .tag_we_o      (tag_we_o),
    .tag_set_o     (tag_set_o),
    .tag_way_mask_o(tag_way_mask_o),
    .flush_cycles_o(flush_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic logic [31:0] exp_cyc(input int n);
    return CntEn ? 32'(n) : 32'd0;
  endfunction

  typedef struct {
    string name;
    int    drain_stall;   // cycles wbuf_empty_i is held low after the request
    int    gnt_set;       // set on which tag_gnt_i is withheld
    int    gnt_stall;     // number of withheld grant cycles
    int    exp_ack;       // cycle (request edge = 0) carrying flush_ack_o
    int    exp_set_cyc;   // cycles tag_set_o shows gnt_set
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"ideal",        0,   0, 0, 258, 1};
    vecs[1] = '{"drain_stall", 10, 128, 0, 268, 1};
    vecs[2] = '{"gnt_bp_17",    0,  17, 3, 261, 4};
    vecs[3] = '{"mixed_255",    5, 255, 2, 265, 3};

    // Reset state
    repeat (2) @(negedge clk_i);
    check("reset_outputs",
          {busy_o, flush_ack_o, tag_req_o, tag_we_o, tag_set_o, tag_way_mask_o, flush_cycles_o}, 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("idle_outputs",
          {busy_o, flush_ack_o, tag_req_o, tag_we_o, tag_set_o, tag_way_mask_o}, 0);

    for (int r = 0; r < 4; r++) begin
      vec_t v;
      int ack_cycle, n_ack, writes, first_req, exp_set, stall_left;
      int set_cycles, busy_bad, set_bad, mask_bad;
      v = vecs[r];
      ack_cycle = 0; n_ack = 0; writes = 0; first_req = 0; exp_set = 0;
      stall_left = v.gnt_stall; set_cycles = 0; busy_bad = 0; set_bad = 0; mask_bad = 0;

      // Cycle 0: one-cycle request, seen at edge 0.
      @(negedge clk_i);
      flush_req_i  = 1'b1;
      wbuf_empty_i = (v.drain_stall == 0);
      tag_gnt_i    = 1'b1;
      for (int k = 1; k <= 1000; k++) begin
        @(negedge clk_i);
        if (k == 1) flush_req_i = 1'b0;
        if (busy_o !== (k <= v.exp_ack)) busy_bad++;
        if (flush_ack_o) begin
          n_ack++;
          if (ack_cycle == 0) ack_cycle = k;
        end
        if (tag_req_o) begin
          if (first_req == 0) first_req = k;
          if (int'(tag_set_o) != exp_set) set_bad++;
          if (tag_way_mask_o !== 8'hFF || tag_we_o !== 1'b1) mask_bad++;
          if (int'(tag_set_o) == v.gnt_set) set_cycles++;
        end else if (tag_we_o !== 1'b0 || tag_set_o !== 8'd0 || tag_way_mask_o !== 8'd0) begin
          mask_bad++;
        end
        // Inputs for edge k; write-buffer activity during the walk must be ignored.
        if (k <= v.drain_stall) wbuf_empty_i = 1'b0;
        else if (k > v.drain_stall + 1) wbuf_empty_i = (k % 7 != 0);
        else wbuf_empty_i = 1'b1;
        tag_gnt_i = !(tag_req_o && exp_set == v.gnt_set && stall_left > 0);
        if (!tag_gnt_i) stall_left--;
        if (tag_req_o && tag_gnt_i) begin
          writes++;
          exp_set++;
        end
        if (ack_cycle != 0 && k == ack_cycle + 1) break;
      end
      $display("-- scenario %s", v.name);
      check({v.name, "_ack_cycle"}, ack_cycle, v.exp_ack);
      check({v.name, "_ack_count"}, n_ack, 1);
      check({v.name, "_writes"}, writes, 256);
      check({v.name, "_first_req"}, first_req, v.drain_stall + 2);
      check({v.name, "_set_order_err"}, set_bad, 0);
      check({v.name, "_mask_we_err"}, mask_bad, 0);
      check({v.name, "_busy_err"}, busy_bad, 0);
      check({v.name, "_set_hold"}, set_cycles, v.exp_set_cyc);
      check({v.name, "_flush_cycles"}, flush_cycles_o, exp_cyc(v.exp_ack));
      repeat (2) @(negedge clk_i);
    end

    // Request held through DONE restarts from set 0; then reset mid-walk at set 100.
    begin
      int ack_cycle;
      bit hit;
      ack_cycle = 0;
      hit = 1'b0;
      @(negedge clk_i);
      flush_req_i  = 1'b1;
      wbuf_empty_i = 1'b1;
      tag_gnt_i    = 1'b1;
      for (int k = 1; k <= 600; k++) begin
        @(negedge clk_i);
        if (flush_ack_o && ack_cycle == 0) ack_cycle = k;
        if (k == 259) begin
          check("held_ack_cycle", ack_cycle, 258);
          check("held_idle_busy", busy_o, 0);
          check("held_flush_cycles", flush_cycles_o, exp_cyc(258));
        end
        if (k == 260) begin
          check("held_restart_drain", {busy_o, tag_req_o}, 2'b10);
          flush_req_i = 1'b0;
        end
        if (k == 261) check("held_restart_set0", {tag_req_o, tag_set_o}, {1'b1, 8'd0});
        if (k > 261 && tag_req_o && tag_set_o == 8'd100) begin
          rst_ni = 1'b0;
          #1;
          check("midwalk_reset_outputs",
                {busy_o, flush_ack_o, tag_req_o, tag_we_o, tag_set_o, tag_way_mask_o, flush_cycles_o}, 0);
          hit = 1'b1;
          break;
        end
      end
      check("midwalk_reset_reached", hit, 1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      begin
        int acks, busys;
        acks = 0;
        busys = 0;
        for (int k = 0; k < 300; k++) begin
          @(negedge clk_i);
          if (flush_ack_o) acks++;
          if (busy_o || tag_req_o) busys++;
        end
        check("post_reset_no_ack", acks, 0);
        check("post_reset_no_resume", busys, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
